count_stream_checker: RTL and testbench
=======================================

Name: count_stream_checker

Overview:
- Stream sink for the 32-bit counter stream (data, valid, ready, last) produced by the counter source in the AXIS FIFO test path.
- Consumes beats, drives ready with optional pseudo-random backpressure, and checks the incrementing sequence and last placement against a programmed terminal value.
- Reports beat, frame and error statistics, and captures the first failure.
- Sits at the FIFO output in simulation and on-board loopback tests.

Parameters:
- LFSR_SEED, 16'hACE1, nonzero reset seed for the backpressure LFSR.
- STOP_ON_ERR, 0, when 1 the block enters HALT on the first error and stops accepting beats.

Ports:
- counter_clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  permits acceptance (IDLE->RUN); deasserting pauses acceptance.
- backpressure_en  in  1  gate ready with LFSR bit 0.
- clear_stats  in  1  one-cycle pulse; clears counters, flags and capture.
- count_up_to  in  32  expected terminal value; last beat carries this value.
- count_up  in  32  stream data.
- count_valid  in  1  stream valid.
- count_last  in  1  stream last.
- count_ready  out  1  stream ready, registered.
- beat_count  out  32  accepted beats, saturating.
- frame_count  out  32  accepted beats with count_last=1, saturating.
- error_count  out  32  beats with at least one error, saturating.
- err_data  out  1  sticky data-mismatch flag.
- err_last  out  1  sticky last-misplacement flag.
- first_err_data  out  32  count_up of the first erroring beat.
- first_err_expected  out  32  expected value at the first erroring beat.
- halted  out  1  high in HALT.

Behaviour:
- Clocking and reset: all state updates on the rising edge of counter_clk; reset is synchronous and active-high.
- Reset values: all outputs 0, expected=0, LFSR=LFSR_SEED, state=IDLE.
- Transfer: occurs on an edge where count_valid=1 and count_ready=1. Nothing else is consumed.
- Ready generation: count_ready registered; next value = (state==RUN) & enable & (~backpressure_en | lfsr[0]).
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle while not in reset.
- State machine:
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0; expected is retained, so a paused frame resumes.
  - RUN -> HALT on an erroring transfer when STOP_ON_ERR=1.
  - HALT exits only on reset. clear_stats does not leave HALT.
- Checks per transfer:
  - data_err = (count_up != expected).
  - last_err = (count_last != (count_up == count_up_to)).
- Expected update per transfer:
  - If count_last=1 or count_up==count_up_to, expected <= 0.
  - Otherwise expected <= count_up+1. This resyncs to the received data, so a single glitch costs one error, not a cascade.
  - 32-bit wrap: expected 32'hFFFF_FFFF+1 -> 0 is legal, with no error.
- Counters:
  - beat_count +1 per transfer.
  - frame_count +1 per transfer with count_last=1.
  - error_count +1 per transfer with data_err|last_err. A beat with both errors counts once but sets both sticky flags.
  - All counters saturate at 32'hFFFF_FFFF.
- First-error capture: loaded only while error_count==0 and the current transfer errs.
- clear_stats: zeroes counters, sticky flags and capture registers the same cycle.
  - If a transfer coincides with clear_stats, clear wins; that beat is not counted.
  - expected and state are untouched.
- count_up_to change mid-frame: applies from the next transfer.
- count_up_to=0: every beat must be 0 with last=1.
- Latency: stats and flags reflect a transfer one cycle after its edge. count_ready responds to enable/backpressure one cycle later.

Decomposition:
- Shared package count_stream_pkg:
  - DATA_W=32.
  - LFSR taps constant.
  - State enum {IDLE, RUN, HALT}.
- Sub-module lfsr16 (seed parameter, enable, 16-bit state out): reusable for source-side throttling.

Test Plan:
1. count_up_to=3, enable=1, backpressure_en=0, compliant source sends 0,1,2,3(last),0,1,2,3(last):
   - count_ready high from the 2nd cycle after enable.
   - beat_count=8, frame_count=2, error_count=0, flags 0.
2. Same as 1 with backpressure_en=1, 200 beats, count_up_to=9:
   - Transfers only when ready=1.
   - frame_count=20, error_count=0.
   - ready observed low at least once.
3. count_up_to=5, source sends 0,1,7,8,9…; last is set on the beat with value 5 when it occurs, expected last at 5:
   - error_count=1, err_data=1.
   - first_err_data=7, first_err_expected=2.
   - Subsequent beats clean.
4. count_up_to=2, source sends 0,1,2 with last=0 on 2, then 3:
   - err_last=1 from the beat 2; beat 3 flagged as data error.
   - error_count=2, frame_count=0.
5. STOP_ON_ERR=1, inject error at beat 4:
   - halted=1 the next cycle; count_ready=0 thereafter.
   - beat_count frozen at 5 despite valid=1.
   - clear_stats zeroes counts but halted stays 1 until reset.
6. Mid-stream reset at beat 3 of count_up_to=7, and clear_stats coincident with a transfer:
   - After reset, all outputs 0 and expected=0; source restarts at 0 with no errors.
   - The coincident beat is not counted.

Source files
------------

// File: rtl/count_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : count_stream_pkg
//  Purpose  : Shared widths, LFSR tap mask, checker state encoding and a
//             saturating-increment helper for the counter-stream checker.
//  Revision : 1.0  initial release
// ============================================================================
package count_stream_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] c_ONE      = 1;
    localparam logic [DATA_W-1:0] c_ALL_ONES = '1;

    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR expressed as a mask
    // over state bits 0,2,3,5; feedback enters at bit 15.
    localparam logic [15:0] c_LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == c_ALL_ONES) ? v : v + c_ONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : count_stream_if
//  Purpose  : Counter stream bundle (data, valid, last, ready).
//             master : stream source (drives data/valid/last)
//             slave  : stream sink   (drives ready)
//  Revision : 1.0  initial release
// ============================================================================
interface count_stream_if;
    import count_stream_pkg::*;

    logic [DATA_W-1:0] count_up;
    logic              count_valid;
    logic              count_last;
    logic              count_ready;

    modport master (output count_up, output count_valid, output count_last,
                    input  count_ready);
    modport slave  (input  count_up, input  count_valid, input  count_last,
                    output count_ready);
endinterface
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr16
//  Purpose  : 16-bit Fibonacci LFSR (taps 16,14,13,11), advances each cycle
//             i_en is high. Used for ready throttling.
//  Ports    : clk, rst (sync active-high), i_en, o_state[15:0]
//  Revision : 1.0  initial release
// ============================================================================
module lfsr16
    import count_stream_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_en,
    output logic      [15:0] o_state
);

    logic [15:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= {^(r_state & c_LFSR_TAPS), r_state[15:1]};
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/count_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module   : count_stream_checker
//  Purpose  : Sink for the incrementing counter stream. Drives a registered
//             ready (optionally throttled by an LFSR), checks data sequence
//             and last placement against count_up_to, keeps saturating
//             beat/frame/error statistics and captures the first error.
//  Ports    : counter_clk, reset (sync active-high), enable, backpressure_en,
//             clear_stats, count_up_to, s_cnt (stream slave), beat_count,
//             frame_count, error_count, err_data, err_last, first_err_data,
//             first_err_expected, halted
//  Revision : 1.0  initial release
// ============================================================================
module count_stream_checker
    import count_stream_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  wire logic              counter_clk,
    input  wire logic              reset,
    input  wire logic              enable,
    input  wire logic              backpressure_en,
    input  wire logic              clear_stats,
    input  wire logic [DATA_W-1:0] count_up_to,
    count_stream_if.slave          s_cnt,
    output logic      [DATA_W-1:0] beat_count,
    output logic      [DATA_W-1:0] frame_count,
    output logic      [DATA_W-1:0] error_count,
    output logic                   err_data,
    output logic                   err_last,
    output logic      [DATA_W-1:0] first_err_data,
    output logic      [DATA_W-1:0] first_err_expected,
    output logic                   halted
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ready;
    logic [DATA_W-1:0] r_expected;
    logic [DATA_W-1:0] r_beat_count;
    logic [DATA_W-1:0] r_frame_count;
    logic [DATA_W-1:0] r_error_count;
    logic              r_err_data;
    logic              r_err_last;
    logic [DATA_W-1:0] r_first_err_data;
    logic [DATA_W-1:0] r_first_err_expected;

    logic [15:0]       w_lfsr;
    logic              w_lfsr_unused;
    logic              w_xfer;
    logic              w_is_term;
    logic              w_data_err;
    logic              w_last_err;
    logic              w_any_err;
    logic              w_halt_now;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (counter_clk),
        .rst     (reset),
        .i_en    (1'b1),
        .o_state (w_lfsr)
    );

    // Only bit 0 gates ready; the rest of the state is intentionally unused.
    assign w_lfsr_unused = ^w_lfsr[15:1];

    assign w_xfer     = s_cnt.count_valid & r_ready;
    assign w_is_term  = (s_cnt.count_up == count_up_to);
    assign w_data_err = (s_cnt.count_up != r_expected);
    assign w_last_err = (s_cnt.count_last != w_is_term);
    assign w_any_err  = w_data_err | w_last_err;
    assign w_halt_now = STOP_ON_ERR && (r_state == ST_RUN) && w_xfer && w_any_err;

    always_ff @(posedge counter_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (enable) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_halt_now)   w_state_nxt = ST_HALT;
                else if (!enable) w_state_nxt = ST_IDLE;
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Ready follows the current state; suppressing it on a halting transfer
    // keeps a second beat from slipping in while the FSM enters HALT.
    always_ff @(posedge counter_clk) begin
        if (reset) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (r_state == ST_RUN) & ~w_halt_now & enable
                     & (~backpressure_en | w_lfsr[0]);
        end
    end

    // Expected value resyncs to received data, so one glitch costs one error.
    always_ff @(posedge counter_clk) begin
        if (reset) begin
            r_expected <= '0;
        end else if (w_xfer) begin
            r_expected <= (s_cnt.count_last | w_is_term) ? '0
                                                         : s_cnt.count_up + c_ONE;
        end
    end

    always_ff @(posedge counter_clk) begin
        if (reset || clear_stats) begin
            r_beat_count         <= '0;
            r_frame_count        <= '0;
            r_error_count        <= '0;
            r_err_data           <= 1'b0;
            r_err_last           <= 1'b0;
            r_first_err_data     <= '0;
            r_first_err_expected <= '0;
        end else if (w_xfer) begin
            r_beat_count <= sat_inc(r_beat_count);
            if (s_cnt.count_last) r_frame_count <= sat_inc(r_frame_count);
            if (w_any_err) begin
                r_error_count <= sat_inc(r_error_count);
                r_err_data    <= r_err_data | w_data_err;
                r_err_last    <= r_err_last | w_last_err;
                if (r_error_count == '0) begin
                    r_first_err_data     <= s_cnt.count_up;
                    r_first_err_expected <= r_expected;
                end
            end
        end
    end

    assign s_cnt.count_ready  = r_ready;
    assign beat_count         = r_beat_count;
    assign frame_count        = r_frame_count;
    assign error_count        = r_error_count;
    assign err_data           = r_err_data;
    assign err_last           = r_err_last;
    assign first_err_data     = r_first_err_data;
    assign first_err_expected = r_first_err_expected;
    assign halted             = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_count_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_count_stream_checker
//  Purpose  : Self-checking bench for count_stream_checker. Two instances
//             (free-running and stop-on-error) see the same stream; a
//             behavioural model predicts every output each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_count_stream_checker;

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_RUN  = 2'd1;
    localparam logic [1:0] M_HALT = 2'd2;

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] exp;
        logic [15:0] lfsr;
        logic        rdy;
        logic [31:0] beats;
        logic [31:0] frames;
        logic [31:0] errs;
        logic        ed;
        logic        el;
        logic [31:0] fd;
        logic [31:0] fe;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst, en, bp, clr, valid, last;
    logic [31:0] upto, data;
    logic        acc;
    logic        track_low, saw_low;
    int          total = 0;
    int          passed = 0;
    mdl_t        m0, m1;

    logic [31:0] b0, f0, e0, fd0, fe0, b1, f1, e1, fd1, fe1;
    logic        ed0, el0, h0, ed1, el1, h1;

    count_stream_if bus0 ();
    count_stream_if bus1 ();

    assign bus0.count_up = data;  assign bus0.count_valid = valid;  assign bus0.count_last = last;
    assign bus1.count_up = data;  assign bus1.count_valid = valid;  assign bus1.count_last = last;

    count_stream_checker #(.LFSR_SEED(16'hACE1), .STOP_ON_ERR(1'b0)) dut0 (
        .counter_clk(clk), .reset(rst), .enable(en), .backpressure_en(bp),
        .clear_stats(clr), .count_up_to(upto), .s_cnt(bus0),
        .beat_count(b0), .frame_count(f0), .error_count(e0),
        .err_data(ed0), .err_last(el0), .first_err_data(fd0),
        .first_err_expected(fe0), .halted(h0));

    count_stream_checker #(.LFSR_SEED(16'hACE1), .STOP_ON_ERR(1'b1)) dut1 (
        .counter_clk(clk), .reset(rst), .enable(en), .backpressure_en(bp),
        .clear_stats(clr), .count_up_to(upto), .s_cnt(bus1),
        .beat_count(b1), .frame_count(f1), .error_count(e1),
        .err_data(ed1), .err_last(el1), .first_err_data(fd1),
        .first_err_expected(fe1), .halted(h1));

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Reference behaviour for one rising edge, from the inputs held before it.
    function automatic mdl_t step(input mdl_t m, input bit stop);
        mdl_t n;
        logic xfer, de, le, term, halt_now;
        n = m;
        if (rst) begin
            n = '0;
            n.lfsr = 16'hACE1;
            return n;
        end
        term     = (data == upto);
        xfer     = valid && m.rdy;
        de       = (data != m.exp);
        le       = (last != term);
        halt_now = stop && xfer && (de || le) && (m.st == M_RUN);
        n.rdy    = (m.st == M_RUN) && !halt_now && en && (!bp || m.lfsr[0]);
        n.lfsr   = {m.lfsr[0] ^ m.lfsr[2] ^ m.lfsr[3] ^ m.lfsr[5], m.lfsr[15:1]};
        if (m.st == M_IDLE && en) n.st = M_RUN;
        else if (m.st == M_RUN && halt_now) n.st = M_HALT;
        else if (m.st == M_RUN && !en) n.st = M_IDLE;
        if (xfer) n.exp = (last || term) ? 32'd0 : data + 32'd1;
        if (clr) begin
            n.beats = 0; n.frames = 0; n.errs = 0;
            n.ed = 0; n.el = 0; n.fd = 0; n.fe = 0;
        end else if (xfer) begin
            n.beats = inc(m.beats);
            if (last) n.frames = inc(m.frames);
            if (de || le) begin
                n.errs = inc(m.errs);
                n.ed   = m.ed | de;
                n.el   = m.el | le;
                if (m.errs == 0) begin
                    n.fd = data;
                    n.fe = m.exp;
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    task automatic cmp(input string p, input mdl_t m, input logic rdy,
                       input logic [31:0] b, input logic [31:0] f, input logic [31:0] e,
                       input logic ed, input logic el, input logic [31:0] fd,
                       input logic [31:0] fe, input logic h);
        chk({p, ".ready"},  {31'd0, rdy}, {31'd0, m.rdy});
        chk({p, ".beats"},  b, m.beats);
        chk({p, ".frames"}, f, m.frames);
        chk({p, ".errors"}, e, m.errs);
        chk({p, ".err_data"}, {31'd0, ed}, {31'd0, m.ed});
        chk({p, ".err_last"}, {31'd0, el}, {31'd0, m.el});
        chk({p, ".first_data"}, fd, m.fd);
        chk({p, ".first_exp"},  fe, m.fe);
        chk({p, ".halted"}, {31'd0, h}, {31'd0, (m.st == M_HALT)});
    endtask

    // One clock: note the handshake, advance the model, compare after the edge.
    task automatic cycle();
        acc = valid && bus0.count_ready;
        if (track_low && !bus0.count_ready) saw_low = 1'b1;
        @(posedge clk);
        m0 = step(m0, 1'b0);
        m1 = step(m1, 1'b1);
        #1;
        cmp("d0", m0, bus0.count_ready, b0, f0, e0, ed0, el0, fd0, fe0, h0);
        cmp("d1", m1, bus1.count_ready, b1, f1, e1, ed1, el1, fd1, fe1, h1);
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        data = d; last = l; valid = 1'b1;
        do begin
            cycle();
            n++;
        end while (!acc && n < 64);
        chk("send_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic pulse_clear();
        valid = 1'b0; clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    initial begin
        logic [31:0] nxt;
        rst = 1; en = 0; bp = 0; clr = 0; valid = 0; last = 0;
        upto = 0; data = 0; acc = 0; track_low = 0; saw_low = 0;

        // Reset state
        idle(2);
        chk("rst_beats", b0, 32'd0);
        chk("rst_ready", {31'd0, bus0.count_ready}, 32'd0);
        chk("rst_halted", {31'd0, h1}, 32'd0);
        rst = 0;
        idle(1);

        // 1: clean frames, no backpressure
        upto = 3; en = 1;
        cycle();
        chk("t1_ready_c1", {31'd0, bus0.count_ready}, 32'd0);
        cycle();
        chk("t1_ready_c2", {31'd0, bus0.count_ready}, 32'd1);
        for (int i = 0; i < 8; i++) send(i % 4, (i % 4) == 3);
        idle(1);
        chk("t1_beats", b0, 32'd8);
        chk("t1_frames", f0, 32'd2);
        chk("t1_errors", e0, 32'd0);
        chk("t1_flags", {30'd0, ed0, el0}, 32'd0);

        // 2: backpressure
        pulse_clear();
        bp = 1; upto = 9; track_low = 1; saw_low = 0;
        for (int i = 0; i < 200; i++) send(i % 10, (i % 10) == 9);
        track_low = 0;
        idle(1);
        chk("t2_frames", f0, 32'd20);
        chk("t2_beats", b0, 32'd200);
        chk("t2_errors", e0, 32'd0);
        chk("t2_ready_low", {31'd0, saw_low}, 32'd1);

        // 3: data glitch resynchronises
        pulse_clear();
        bp = 0; upto = 5;
        send(0, 0); send(1, 0); send(7, 0); send(8, 0);
        send(9, 0); send(10, 0); send(11, 0);
        idle(1);
        chk("t3_errors", e0, 32'd1);
        chk("t3_err_data", {31'd0, ed0}, 32'd1);
        chk("t3_err_last", {31'd0, el0}, 32'd0);
        chk("t3_first_data", fd0, 32'd7);
        chk("t3_first_exp", fe0, 32'd2);
        upto = 12;
        send(12, 1);
        idle(1);
        chk("t3_upto_change", e0, 32'd1);

        // 4: missing last
        pulse_clear();
        upto = 2;
        send(0, 0); send(1, 0); send(2, 0); send(3, 0);
        idle(1);
        chk("t4_errors", e0, 32'd2);
        chk("t4_frames", f0, 32'd0);
        chk("t4_err_last", {31'd0, el0}, 32'd1);
        chk("t4_err_data", {31'd0, ed0}, 32'd1);
        chk("t4_first_data", fd0, 32'd2);

        // 32-bit wrap of expected is legal
        pulse_clear();
        upto = 5;
        send(32'hFFFF_FFFF, 0); send(0, 0);
        idle(1);
        chk("wrap_errors", e0, 32'd1);
        chk("wrap_first", fd0, 32'hFFFF_FFFF);

        // 5: stop on error
        rst = 1; idle(2); rst = 0;
        chk("t5_rst_beats", b1, 32'd0);
        chk("t5_rst_halted", {31'd0, h1}, 32'd0);
        upto = 7;
        idle(2);
        send(0, 0); send(1, 0); send(2, 0); send(3, 0); send(9, 0);
        chk("t5_halted_next", {31'd0, h1}, 32'd1);
        chk("t5_ready_off", {31'd0, bus1.count_ready}, 32'd0);
        data = 10; last = 0; valid = 1;
        for (int i = 0; i < 6; i++) cycle();
        chk("t5_beats_frozen", b1, 32'd5);
        chk("t5_ready_still_off", {31'd0, bus1.count_ready}, 32'd0);
        pulse_clear();
        idle(1);
        chk("t5_clr_beats", b1, 32'd0);
        chk("t5_clr_errors", e1, 32'd0);
        chk("t5_clr_halted", {31'd0, h1}, 32'd1);

        // 6: mid-stream reset and clear coincident with a transfer
        rst = 1; idle(1); rst = 0;
        idle(2);
        send(0, 0); send(1, 0); send(2, 0);
        valid = 0; rst = 1; cycle(); rst = 0;
        chk("t6_rst_beats", b0, 32'd0);
        chk("t6_rst_halted", {31'd0, h1}, 32'd0);
        for (int i = 0; i < 8; i++) send(i, i == 7);
        clr = 1;
        send(0, 0);
        clr = 0;
        chk("t6_coincident", b0, 32'd0);
        send(1, 0);
        idle(1);
        chk("t6_after_beats", b0, 32'd1);
        chk("t6_after_errors", e0, 32'd0);

        // Randomised traffic, mostly compliant with occasional faults
        nxt = 0; upto = 4;
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom % 200) == 0;
            en  = ($urandom % 16) != 0;
            bp  = $urandom % 2;
            clr = ($urandom % 64) == 0;
            if (($urandom % 100) == 0) upto = $urandom % 6;
            if (acc || !valid) begin
                valid = ($urandom % 4) != 0;
                data  = (($urandom % 30) == 0) ? ($urandom % 8) : nxt;
                last  = (data == upto);
                if (($urandom % 40) == 0) last = !last;
            end
            cycle();
            if (acc) nxt = (last || data == upto) ? 32'd0 : data + 32'd1;
            if (rst) nxt = 0;
        end
        rst = 0; clr = 0;
        idle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
